// File: rtl/alu_seq.sv
// Sequential bus ALU: operand registers, single-cycle ops,
// iterative shift-add multiply and a tri-state result driver.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] busIN,
  input  logic             A_in,
  input  logic             B_in,
  input  logic [3:0]       select,
  input  logic             start,
  input  logic             out_EN,
  output wire  [WIDTH-1:0] busOUT,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags
);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_XNOR = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  localparam int MSB = WIDTH - 1;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   r;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] addend;
  logic               go;
  logic               go_mul;
  logic               last;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH-1:0]   mul_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (go_mul) state_nxt = MUL;
      MUL:  if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    go     = 1'b0;
    go_mul = 1'b0;
    last   = 1'b0;
    unique case (state)
      IDLE: begin
        go     = start && (select != OP_MUL);
        go_mul = start && (select == OP_MUL);
      end
      MUL: begin
        busy = 1'b1;
        last = (cnt == SHW'(WIDTH - 1));
      end
      default: ;
    endcase
  end

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sh   = b[SHW-1:0];

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (select)
      OP_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[MSB] == b[MSB]) &&
                (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (a[MSB] != b[MSB]) &&
                (diff[MSB] != a[MSB]);
      end
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_NOT:  alu_r = ~a;
      OP_XNOR: alu_r = ~(a ^ b);
      OP_SHL:  alu_r = a << sh;
      OP_SHR:  alu_r = a >> sh;
      OP_SRA:  alu_r = $signed(a) >>> sh;
      default: alu_r = '0;
    endcase
  end

  // One multiplier bit per step, weighted by the step index.
  assign addend   = b[cnt] ? ({{WIDTH{1'b0}}, a} << cnt)
                           : '0;
  assign prod_nxt = prod + addend;
  assign mul_r    = prod_nxt[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a     <= '0;
      b     <= '0;
      r     <= '0;
      flags <= '0;
      cnt   <= '0;
      prod  <= '0;
      done  <= 1'b0;
    end else begin
      if (!busy) begin
        if (A_in) a <= busIN;
        if (B_in) b <= busIN;
      end
      done <= go || last;
      if (go_mul) begin
        prod <= '0;
        cnt  <= '0;
      end else if (busy) begin
        prod <= prod_nxt;
        cnt  <= cnt + SHW'(1);
      end
      if (go) begin
        r     <= alu_r;
        flags <= {alu_r == '0, alu_r[MSB],
                  alu_c, alu_v};
      end else if (last) begin
        r     <= mul_r;
        flags <= {mul_r == '0, mul_r[MSB],
                  |prod_nxt[2*WIDTH-1:WIDTH],
                  1'b0};
      end
    end
  end

  assign busOUT = (out_EN && !busy) ? r : 'z;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with an integer reference model
// and a per-cycle compare process.
module tb_alu_seq;

  logic        clk;
  logic        reset_n;
  logic [15:0] busIN;
  logic        A_in;
  logic        B_in;
  logic [3:0]  select;
  logic        start;
  logic        out_EN;
  tri1  [15:0] bus_net;
  logic        busy;
  logic        done;
  logic [3:0]  flags;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .busIN  (busIN),
    .A_in   (A_in),
    .B_in   (B_in),
    .select (select),
    .start  (start),
    .out_EN (out_EN),
    .busOUT (bus_net),
    .busy   (busy),
    .done   (done),
    .flags  (flags)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {Z,N,C,V,R}.
  function automatic logic [19:0] ref_op(
      input logic [3:0] op,
      input int unsigned a,
      input int unsigned b);
    int unsigned rr;
    int sa, sb, sr, sh;
    bit c, v;
    logic [15:0] r16;
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    sh = int'(b % 16);
    c = 0;
    v = 0;
    case (op)
      4'h0: begin
        rr = a + b;
        c  = rr > 65535;
        sr = sa + sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      4'h1: begin
        rr = a - b;
        c  = a < b;
        sr = sa - sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      4'h2: rr = a & b;
      4'h3: rr = a | b;
      4'h4: rr = a ^ b;
      4'h5: rr = ~a;
      4'h6: rr = ~(a ^ b);
      4'h7: rr = a << sh;
      4'h8: rr = a >> sh;
      4'h9: rr = int'(unsigned'(sa >>> sh));
      default: rr = 0;
    endcase
    r16 = rr[15:0];
    return {r16 == 0, r16[15], c, v, r16};
  endfunction

  bit [15:0] m_a, m_b, m_r;
  bit [3:0]  m_f;
  bit        m_busy, m_done;
  int        m_left;

  always @(posedge clk or negedge reset_n) begin
    bit wb;
    longint unsigned p;
    if (!reset_n) begin
      m_a = 0; m_b = 0; m_r = 0; m_f = 0;
      m_busy = 0; m_done = 0; m_left = 0;
    end else begin
      wb = m_busy;
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          p = longint'(m_a) * longint'(m_b);
          m_r = p[15:0];
          m_f = {m_r == 0, m_r[15], (p >> 16) != 0, 1'b0};
          m_busy = 0;
          m_done = 1;
        end
      end else if (start) begin
        if (select == 4'hA) begin
          m_busy = 1;
          m_left = 16;
        end else begin
          {m_f, m_r} = ref_op(select, m_a, m_b);
          m_done = 1;
        end
      end
      if (!wb) begin
        if (A_in) m_a = busIN;
        if (B_in) m_b = busIN;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("flags", 32'(flags), 32'(m_f));
      chk("bus", 32'(bus_net),
          32'((out_EN && !m_busy) ? m_r : 16'hFFFF));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [15:0] a,
                      input logic [15:0] b);
    busIN = a; A_in = 1;
    tick();
    A_in = 0; busIN = b; B_in = 1;
    tick();
    B_in = 0;
  endtask

  task automatic op(input logic [3:0] s);
    select = s; start = 1;
    tick();
    start = 0;
  endtask

  task automatic res(input string name,
                     input logic [15:0] r,
                     input logic [3:0] f);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_r"}, 32'(bus_net), 32'(r));
    chk({name, "_f"}, 32'(flags), 32'(f));
  endtask

  initial begin
    int cyc;
    int dn;
    reset_n = 0; busIN = 0; A_in = 0; B_in = 0;
    select = 0; start = 0; out_EN = 1;
    tick(); tick();
    chk("rst_bus", 32'(bus_net), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk_en = 1;
    reset_n = 1;
    tick();

    load(16'h7FFF, 16'h0001); op(4'h0);
    res("add_ovf", 16'h8000, 4'h5);
    tick();
    chk("add_done_low", 32'(done), 32'h0);

    load(16'h0003, 16'h0005); op(4'h1);
    res("sub_borrow", 16'hFFFE, 4'h6);
    load(16'h1234, 16'h1234); op(4'h1);
    res("sub_zero", 16'h0000, 4'h8);

    load(16'h8000, 16'h0004);
    op(4'h9); res("sra", 16'hF800, 4'h4);
    op(4'h8); res("shr", 16'h0800, 4'h0);
    op(4'h7); res("shl", 16'h0000, 4'h8);
    load(16'h00FF, 16'h0004);
    op(4'h5); res("not", 16'hFF00, 4'h4);

    load(16'h0001, 16'h0002);
    busIN = 16'h0010; A_in = 1; select = 0; start = 1;
    tick();
    A_in = 0; start = 0;
    res("same_edge", 16'h0003, 4'h0);
    op(4'h0); res("after_load", 16'h0012, 4'h0);

    select = 4'h2; start = 1;
    tick();
    res("b2b_and", 16'h0000, 4'h8);
    select = 4'h3;
    tick();
    start = 0;
    res("b2b_or", 16'h0012, 4'h0);
    tick();
    chk("b2b_done_low", 32'(done), 32'h0);

    load(16'h0123, 16'h0045); op(4'hA);
    cyc = 0; dn = 0;
    while (busy && cyc < 40) begin
      tick();
      cyc++;
      if (done) dn++;
    end
    chk("mul_lat", 32'(cyc), 32'd16);
    chk("mul_dn", 32'(dn), 32'd1);
    res("mul", 16'h4E6F, 4'h0);
    tick();
    chk("mul_done_low", 32'(done), 32'h0);

    load(16'h1000, 16'h0010); op(4'hA);
    tick();
    busIN = 16'hFFFF; A_in = 1;
    tick();
    A_in = 0; select = 4'h0; start = 1;
    tick();
    start = 0;
    chk("mul_busy", 32'(busy), 32'h1);
    chk("mul_hiz", 32'(bus_net), 32'hFFFF);
    cyc = 0;
    while (busy && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("mul2_lat", 32'(cyc), 32'd13);
    res("mul_trunc", 16'h0000, 4'hA);
    op(4'h0); res("mul_lock", 16'h1010, 4'h0);

    load(16'h0005, 16'h0003); op(4'hA);
    tick(); tick(); tick(); tick();
    reset_n = 0;
    #1;
    chk("amid_busy", 32'(busy), 32'h0);
    chk("amid_flags", 32'(flags), 32'h0);
    chk("amid_bus_en", 32'(bus_net), 32'h0);
    out_EN = 0;
    #1;
    chk("amid_bus_z", 32'(bus_net), 32'hFFFF);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dn++;
    end
    chk("amid_nodone", 32'(dn), 32'd0);
    reset_n = 1; out_EN = 1;
    tick();
    op(4'h0); res("post_rst", 16'h0000, 4'h8);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
